// File: rtl/logicnet_seq_pkg.sv
// logicnet_seq_pkg: shared FSM state type, LUT address width and CONN entry extraction
// for the time-multiplexed LogicNet layer sequencer.
`default_nettype none
package logicnet_seq_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    EVAL  = 2'd1,
    DRAIN = 2'd2,
    OUT   = 2'd3
  } state_e;

  localparam int LUT_AW     = 8;
  localparam int CONN_MAX_W = 4096;

  // Returns the input index stored in CONN entry [n*fanin+k]; entries are idx_w bits wide.
  function automatic logic [31:0] conn_idx(input logic [CONN_MAX_W-1:0] conn,
                                           input int n, input int k,
                                           input int fanin, input int idx_w);
    logic [31:0] mask;
    mask = (32'd1 << idx_w) - 32'd1;
    return 32'(conn >> ((n * fanin + k) * idx_w)) & mask;
  endfunction

endpackage
`default_nettype wire

// File: rtl/logicnet_fanin_gather.sv
// logicnet_fanin_gather: combinational fan-in selection building one neuron's LUT address
// from the captured activation frame and the CONN connectivity table.
`default_nettype none
module logicnet_fanin_gather
  import logicnet_seq_pkg::*;
#(
  parameter int IN_W      = 64,
  parameter int N_NEURONS = 16,
  parameter int FANIN     = 8,
  parameter logic [N_NEURONS*FANIN*$clog2(IN_W)-1:0] CONN = '0
) (
  input  logic [IN_W-1:0]              frame_i,
  input  logic [$clog2(N_NEURONS)-1:0] ncnt_i,
  output logic [LUT_AW-1:0]            addr_o
);

  localparam int IDX_W = $clog2(IN_W);

  logic [CONN_MAX_W-1:0] conn_ext;
  assign conn_ext = CONN_MAX_W'(CONN);

  always_comb begin
    logic [IDX_W-1:0] idx;
    addr_o = '0;
    for (int k = 0; k < FANIN; k++) begin
      idx       = IDX_W'(conn_idx(conn_ext, int'(ncnt_i), k, FANIN, IDX_W));
      addr_o[k] = frame_i[idx];
    end
  end

endmodule
`default_nettype wire

// File: rtl/logicnet_layer_seq.sv
// logicnet_layer_seq: issues one shared neuron-LUT lookup per cycle for a captured frame and
// collects results into an output vector. Perf counters are present with LAYER_SEQ_PERF_EN.
`default_nettype none
module logicnet_layer_seq
  import logicnet_seq_pkg::*;
#(
  parameter int IN_W      = 64,
  parameter int N_NEURONS = 16,
  parameter int FANIN     = 8,
  parameter logic [N_NEURONS*FANIN*$clog2(IN_W)-1:0] CONN = '0
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         s_valid,
  output logic                         s_ready,
  input  logic [IN_W-1:0]              s_data,
  output logic                         lut_en,
  output logic [$clog2(N_NEURONS)-1:0] lut_nidx,
  output logic [LUT_AW-1:0]            lut_addr,
  input  logic                         lut_rdata,
  output logic                         m_valid,
  input  logic                         m_ready,
  output logic [N_NEURONS-1:0]         m_data
`ifdef LAYER_SEQ_PERF_EN
  ,
  output logic [31:0]                  perf_frames,
  output logic [31:0]                  perf_stall
`endif
);

  localparam int NW = $clog2(N_NEURONS);

  state_e               state_q, state_d;
  logic [IN_W-1:0]      frame_q, frame_d;
  logic [NW-1:0]        ncnt_q, ncnt_d;
  logic                 lut_en_q;
  logic [NW-1:0]        lut_nidx_q;
  logic [LUT_AW-1:0]    lut_addr_q, addr_w;
  logic                 en_dly_q;
  logic [NW-1:0]        nidx_dly_q;
  logic [N_NEURONS-1:0] m_data_q, m_data_d;
  logic                 s_hs_w;

  assign s_ready = (state_q == IDLE) && !rst;
  assign m_valid = (state_q == OUT);
  assign s_hs_w  = s_valid && s_ready;

  always_comb begin
    state_d  = state_q;
    frame_d  = frame_q;
    ncnt_d   = ncnt_q;
    m_data_d = m_data_q;
    if (en_dly_q) m_data_d[nidx_dly_q] = lut_rdata;
    case (state_q)
      IDLE: begin
        if (s_hs_w) begin
          frame_d  = s_data;
          m_data_d = '0;
          ncnt_d   = '0;
          state_d  = EVAL;
        end
      end
      EVAL: begin
        if (ncnt_q == NW'(N_NEURONS - 1)) state_d = DRAIN;
        else                              ncnt_d  = ncnt_q + 1'b1;
      end
      DRAIN:   state_d = OUT;
      OUT:     if (m_ready) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Address is formed from next-state frame/counter so the lookup outputs can be registered.
  logicnet_fanin_gather #(
    .IN_W      (IN_W),
    .N_NEURONS (N_NEURONS),
    .FANIN     (FANIN),
    .CONN      (CONN)
  ) u_gather (
    .frame_i (frame_d),
    .ncnt_i  (ncnt_d),
    .addr_o  (addr_w)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= IDLE;
      frame_q    <= '0;
      ncnt_q     <= '0;
      lut_en_q   <= 1'b0;
      lut_nidx_q <= '0;
      lut_addr_q <= '0;
      en_dly_q   <= 1'b0;
      nidx_dly_q <= '0;
      m_data_q   <= '0;
    end else begin
      state_q    <= state_d;
      frame_q    <= frame_d;
      ncnt_q     <= ncnt_d;
      lut_en_q   <= (state_d == EVAL);
      lut_nidx_q <= ncnt_d;
      if (state_d == EVAL) lut_addr_q <= addr_w;
      en_dly_q   <= lut_en_q;
      nidx_dly_q <= lut_nidx_q;
      m_data_q   <= m_data_d;
    end
  end

  assign lut_en   = lut_en_q;
  assign lut_nidx = lut_nidx_q;
  assign lut_addr = lut_addr_q;
  assign m_data   = m_data_q;

`ifdef LAYER_SEQ_PERF_EN
  logic [31:0] perf_frames_q, perf_stall_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      perf_frames_q <= '0;
      perf_stall_q  <= '0;
    end else begin
      if (m_valid && m_ready && (perf_frames_q != '1))  perf_frames_q <= perf_frames_q + 32'd1;
      if (m_valid && !m_ready && (perf_stall_q != '1))  perf_stall_q  <= perf_stall_q + 32'd1;
    end
  end

  assign perf_frames = perf_frames_q;
  assign perf_stall  = perf_stall_q;
`endif

endmodule
`default_nettype wire

// File: tb/tb_logicnet_layer_seq.sv
// Self-checking bench: identity-connectivity DUT plus a shared-fan-in DUT, checked against a
// frame-level model (fan-in table lookup, XOR / AND LUT functions, cycle schedule from handshake).
`default_nettype none
module tb_logicnet_layer_seq;

  localparam int N  = 4;
  localparam int IW = 64;
  localparam int XW = 6;
  localparam int CW = N * 8 * XW;

  function automatic logic [CW-1:0] mk_conn_id();
    logic [CW-1:0] r;
    r = '0;
    for (int n = 0; n < N; n++)
      for (int k = 0; k < 8; k++)
        r[(n*8+k)*XW +: XW] = XW'(n * 8 + k);
    return r;
  endfunction

  localparam logic [CW-1:0] CONN_ID = mk_conn_id();
  localparam logic [CW-1:0] CONN_SH = '0;

  logic          clk, rst;
  logic          s_valid, s_ready, sh_s_ready;
  logic [IW-1:0] s_data;
  logic          lut_en, sh_lut_en;
  logic [1:0]    lut_nidx, sh_lut_nidx;
  logic [7:0]    lut_addr, sh_lut_addr;
  logic          lut_rdata, sh_lut_rdata;
  logic          m_valid, sh_m_valid, m_ready;
  logic [N-1:0]  m_data, sh_m_data;
`ifdef LAYER_SEQ_PERF_EN
  logic [31:0]   perf_frames, perf_stall, sh_perf_frames, sh_perf_stall;
`endif

  logicnet_layer_seq #(.IN_W(IW), .N_NEURONS(N), .FANIN(8), .CONN(CONN_ID)) u_dut (
    .clk(clk), .rst(rst), .s_valid(s_valid), .s_ready(s_ready), .s_data(s_data),
    .lut_en(lut_en), .lut_nidx(lut_nidx), .lut_addr(lut_addr), .lut_rdata(lut_rdata),
    .m_valid(m_valid), .m_ready(m_ready), .m_data(m_data)
`ifdef LAYER_SEQ_PERF_EN
    , .perf_frames(perf_frames), .perf_stall(perf_stall)
`endif
  );

  logicnet_layer_seq #(.IN_W(IW), .N_NEURONS(N), .FANIN(8), .CONN(CONN_SH)) u_dut_sh (
    .clk(clk), .rst(rst), .s_valid(s_valid), .s_ready(sh_s_ready), .s_data(s_data),
    .lut_en(sh_lut_en), .lut_nidx(sh_lut_nidx), .lut_addr(sh_lut_addr),
    .lut_rdata(sh_lut_rdata), .m_valid(sh_m_valid), .m_ready(m_ready), .m_data(sh_m_data)
`ifdef LAYER_SEQ_PERF_EN
    , .perf_frames(sh_perf_frames), .perf_stall(sh_perf_stall)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // LUT resources: one-cycle latency; garbage when not strobed.
  always @(posedge clk) begin
    lut_rdata    <= lut_en    ? ^lut_addr    : 1'($urandom);
    sh_lut_rdata <= sh_lut_en ? &sh_lut_addr : 1'($urandom);
  end

  int n_checks = 0;
  int n_fail   = 0;
  int exp_frames = 0;
  int exp_stall  = 0;
  int conn_tab[N*8];

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  function automatic logic [7:0] exp_addr(input logic [63:0] d, input int n);
    logic [7:0] a;
    for (int k = 0; k < 8; k++) a[k] = d[conn_tab[n*8+k]];
    return a;
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check_perf();
`ifdef LAYER_SEQ_PERF_EN
    chk("perf_frames", 64'(perf_frames), 64'(exp_frames));
    chk("perf_stall",  64'(perf_stall),  64'(exp_stall));
`endif
  endtask

  task automatic run_frame(input logic [63:0] d, input int stall, input bit hold_valid);
    int t;
    logic [N-1:0] exp_m, exp_sh;
    for (int n = 0; n < N; n++) begin
      exp_m[n]  = ^exp_addr(d, n);
      exp_sh[n] = d[0];
    end
    s_valid = 1'b1;
    s_data  = d;
    t = 0;
    while (!s_ready && t < 50) begin
      step();
      t++;
    end
    if (!s_ready) begin
      chk("s_ready_timeout", 64'(s_ready), 64'(1));
      s_valid = 1'b0;
      return;
    end
    step();
    s_valid = hold_valid;
    s_data  = {$urandom, $urandom};
    for (int c = 0; c < N; c++) begin
      chk("lut_en",     64'(lut_en),      64'(1));
      chk("lut_nidx",   64'(lut_nidx),    64'(c));
      chk("lut_addr",   64'(lut_addr),    64'(exp_addr(d, c)));
      chk("sh_addr",    64'(sh_lut_addr), 64'({8{d[0]}}));
      chk("busy_ready", 64'(s_ready),     64'(0));
      chk("early_mval", 64'(m_valid),     64'(0));
      step();
    end
    chk("drain_en",   64'(lut_en),  64'(0));
    chk("drain_mval", 64'(m_valid), 64'(0));
    step();
    m_ready = (stall == 0);
    chk("m_valid",   64'(m_valid),    64'(1));
    chk("m_data",    64'(m_data),     64'(exp_m));
    chk("sh_m_data", 64'(sh_m_data),  64'(exp_sh));
    chk("sh_mval",   64'(sh_m_valid), 64'(1));
    for (int i = 1; i <= stall; i++) begin
      step();
      if (i == stall) m_ready = 1'b1;
      chk("stall_mval",  64'(m_valid), 64'(1));
      chk("stall_data",  64'(m_data),  64'(exp_m));
      chk("stall_ready", 64'(s_ready), 64'(0));
    end
    step();
    exp_frames++;
    exp_stall += stall;
    chk("post_mval",  64'(m_valid), 64'(0));
    chk("post_ready", 64'(s_ready), 64'(1));
  endtask

  initial begin
    #2_000_000;
    $display("FAIL global_timeout got=running exp=finished");
    $fatal(1, "timeout");
  end

  initial begin
    for (int i = 0; i < N*8; i++) conn_tab[i] = i;
    rst = 1'b1; s_valid = 1'b0; s_data = '0; m_ready = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_s_ready", 64'(s_ready),  64'(0));
    chk("rst_m_valid", 64'(m_valid),  64'(0));
    chk("rst_m_data",  64'(m_data),   64'(0));
    chk("rst_lut_en",  64'(lut_en),   64'(0));
    chk("rst_nidx",    64'(lut_nidx), 64'(0));
    chk("rst_addr",    64'(lut_addr), 64'(0));
    check_perf();
    rst = 1'b0;
    #1;
    chk("rel_s_ready", 64'(s_ready), 64'(1));
    step();

    // Identity example: bytes FF,07,03,01 give 4'b1010.
    m_ready = 1'b1;
    run_frame(64'h0000_0000_0103_07FF, 0, 1'b0);
    chk("example_m_data", 64'(m_data), 64'(4'b1010));
    check_perf();

    // Backpressure for 10 cycles.
    run_frame({$urandom, $urandom}, 10, 1'b0);
    check_perf();

    // Back-to-back frames with s_valid and m_ready held high.
    m_ready = 1'b1;
    for (int i = 0; i < 3; i++) run_frame({$urandom, $urandom} | 64'd1, 0, 1'b1);
    s_valid = 1'b0;
    check_perf();

    // Async reset at issue of neuron 2.
    s_valid = 1'b1;
    s_data  = 64'h0000_0000_0000_0001;
    while (!s_ready) step();
    step();
    s_valid = 1'b0;
    step();
    step();
    chk("pre_rst_nidx", 64'(lut_nidx), 64'(2));
    chk("pre_rst_data", 64'(m_data),   64'(1));
    #2 rst = 1'b1;
    #1;
    chk("arst_m_valid", 64'(m_valid), 64'(0));
    chk("arst_m_data",  64'(m_data),  64'(0));
    chk("arst_lut_en",  64'(lut_en),  64'(0));
    chk("arst_s_ready", 64'(s_ready), 64'(0));
    exp_frames = 0;
    exp_stall  = 0;
    step();
    rst = 1'b0;
    #1;
    chk("arst_rel_ready", 64'(s_ready), 64'(1));
    check_perf();
    run_frame(64'hDEAD_BEEF_0F1E_2D3B, 2, 1'b0);
    check_perf();

    // Randomized frames.
    for (int i = 0; i < 10; i++) begin
      m_ready = 1'($urandom);
      run_frame({$urandom, $urandom}, int'($urandom_range(0, 3)), 1'b0);
    end
    check_perf();

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
